// File: rtl/hd44780_lcd_ctrl_pkg.sv
// hd44780_lcd_ctrl_pkg: instruction codes, state encodings and DDRAM row-base helper
package hd44780_lcd_ctrl_pkg;
  localparam logic [7:0] CMD_FS4    = 8'h28;
  localparam logic [7:0] CMD_FS8    = 8'h38;
  localparam logic [7:0] CMD_DC     = 8'h0C;
  localparam logic [7:0] CMD_CD     = 8'h01;
  localparam logic [7:0] CMD_EM     = 8'h06;
  localparam logic [7:0] CMD_SDDRAM = 8'h80;
  localparam logic [7:0] CMD_WAKE   = 8'h30;
  localparam logic [7:0] CMD_WAKE4  = 8'h20;
  typedef enum logic [2:0] {S_PWR, S_WAKE, S_CFG, S_IDLE, S_CLEAR, S_REFRESH} st_t;
  typedef enum logic [2:0] {X_IDLE, X_SETUP, X_HIGH, X_LOW, X_WAIT} xst_t;
  // Line 2/3 of a 4-line panel continue lines 0/1 at offset COLS
  function automatic logic [7:0] sddram(input logic [1:0] row, input int cols);
    return CMD_SDDRAM | 8'((row[0] ? 'h40 : 0) + (row[1] ? cols : 0));
  endfunction
endpackage

// File: rtl/hd44780_lcd_ctrl_xfer.sv
// hd44780_lcd_ctrl_xfer: sends one byte (or a lone high nibble) with E timing and post-byte wait
//   clk, rst_n              clock, asynchronous active-low reset
//   i_start                 accepted only while o_idle
//   i_byte, i_rs            byte and register select
//   i_single                4-bit bus: send the high nibble only
//   i_long                  force the T_CLR wait (Clear Display always gets it)
//   o_idle, o_done          ready for a byte / one-cycle pulse at end of the wait
//   o_e, o_rs, o_db         LCD pins
module hd44780_lcd_ctrl_xfer import hd44780_lcd_ctrl_pkg::*; #(
  parameter int BUS_WIDTH = 4,
  parameter int T_E       = 20,
  parameter int T_CMD     = 20,
  parameter int T_CLR     = 2500
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic [7:0]           i_byte,
  input  logic                 i_rs,
  input  logic                 i_single,
  input  logic                 i_long,
  output logic                 o_idle,
  output logic                 o_done,
  output logic                 o_e,
  output logic                 o_rs,
  output logic [BUS_WIDTH-1:0] o_db
);
  xst_t r_st, w_nx;
  logic [31:0] r_cnt;
  logic [7:0] r_byte;
  logic r_rs, r_lo, r_single, r_long;
  logic w_zero, w_two;
  assign w_zero = r_cnt == 0;
  assign w_two = BUS_WIDTH == 4 && !r_lo && !r_single;
  assign o_idle = r_st == X_IDLE;
  assign o_done = r_st == X_WAIT && w_zero;
  assign o_e = r_st == X_HIGH;
  assign o_rs = r_rs;
  if (BUS_WIDTH == 8) begin : g_db8
    assign o_db = r_byte;
  end else begin : g_db4
    assign o_db = r_lo ? r_byte[3:0] : r_byte[7:4];
  end
  always_comb begin
    w_nx = r_st;
    case (r_st)
      X_IDLE:  w_nx = i_start ? X_SETUP : X_IDLE;
      X_SETUP: w_nx = X_HIGH;
      X_HIGH:  w_nx = w_zero ? X_LOW : X_HIGH;
      X_LOW:   w_nx = !w_zero ? X_LOW : w_two ? X_SETUP : X_WAIT;
      default: w_nx = w_zero ? X_IDLE : X_WAIT;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_st <= X_IDLE;
      r_cnt <= '0;
      r_byte <= '0;
      r_rs <= 1'b0;
      r_lo <= 1'b0;
      r_single <= 1'b0;
      r_long <= 1'b0;
    end else begin
      r_st <= w_nx;
      r_cnt <= w_nx != r_st ? (w_nx == X_WAIT ? (r_long ? 32'(T_CLR - 1) : 32'(T_CMD - 1)) : 32'(T_E - 1))
                            : w_zero ? r_cnt : r_cnt - 32'd1;
      if (o_idle && i_start) begin
        r_byte <= i_byte;
        r_rs <= i_rs;
        r_single <= i_single;
        r_long <= i_long || (!i_rs && i_byte == CMD_CD);
        r_lo <= 1'b0;
      end else if (r_st == X_LOW && w_nx == X_SETUP) r_lo <= 1'b1;
    end
endmodule

// File: rtl/hd44780_lcd_ctrl.sv
// hd44780_lcd_ctrl: HD44780 character-LCD controller with power-up init, clear and framebuffer refresh
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_wr_en/row/col/data       framebuffer write port
//   i_trg, i_clr               refresh / clear-display request pulses
//   o_busy, o_init_done        status
//   o_e, o_rs, o_db            LCD pins
module hd44780_lcd_ctrl import hd44780_lcd_ctrl_pkg::*; #(
  parameter int BUS_WIDTH = 4,
  parameter int ROWS      = 4,
  parameter int COLS      = 16,
  parameter int T_E       = 20,
  parameter int T_CMD     = 20,
  parameter int T_CLR     = 2500,
  parameter int T_PWR     = 50000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_wr_en,
  input  logic [1:0]           i_wr_row,
  input  logic [4:0]           i_wr_col,
  input  logic [7:0]           i_wr_data,
  input  logic                 i_trg,
  input  logic                 i_clr,
  output logic                 o_busy,
  output logic                 o_init_done,
  output logic                 o_e,
  output logic                 o_rs,
  output logic [BUS_WIDTH-1:0] o_db
);
  localparam logic [7:0] FS = (BUS_WIDTH == 8 ? CMD_FS8 : CMD_FS4) & (ROWS == 1 ? 8'hF7 : 8'hFF);
  localparam logic [1:0] WAKE_LAST = BUS_WIDTH == 8 ? 2'd2 : 2'd3;
  st_t r_st, w_nx;
  logic [31:0] r_cnt;
  logic [1:0] r_idx, r_row;
  logic [4:0] r_col;
  logic r_ph, r_init, r_clr_p, r_trg_p;
  logic [7:0] r_fb [128];
  logic w_wr_ok, w_idle, w_done, w_start, w_rs, w_single, w_long;
  logic [7:0] w_byte, w_fb;
  assign w_wr_ok = i_wr_en && {1'b0, i_wr_row} < 3'(ROWS) && {1'b0, i_wr_col} < 6'(COLS);
  // Same-cycle write to the cell being fetched wins over the stored value
  assign w_fb = w_wr_ok && {i_wr_row, i_wr_col} == {r_row, r_col} ? i_wr_data : r_fb[{r_row, r_col}];
  assign w_start = w_idle && r_st != S_PWR && r_st != S_IDLE;
  assign o_busy = r_st != S_IDLE || r_clr_p || r_trg_p;
  assign o_init_done = r_init;
  always_comb begin
    w_nx = r_st;
    w_byte = 8'h00;
    w_rs = 1'b0;
    w_single = 1'b0;
    w_long = 1'b0;
    case (r_st)
      S_PWR: w_nx = r_cnt == 0 ? S_WAKE : S_PWR;
      S_WAKE: begin
        w_byte = r_idx == 2'd3 ? CMD_WAKE4 : CMD_WAKE;
        w_single = 1'b1;
        w_long = r_idx != 2'd3;
        w_nx = w_done && r_idx == WAKE_LAST ? S_CFG : S_WAKE;
      end
      S_CFG: begin
        w_byte = r_idx == 2'd0 ? FS : r_idx == 2'd1 ? CMD_DC : r_idx == 2'd2 ? CMD_CD : CMD_EM;
        w_nx = w_done && r_idx == 2'd3 ? S_IDLE : S_CFG;
      end
      S_IDLE: w_nx = r_clr_p ? S_CLEAR : r_trg_p ? S_REFRESH : S_IDLE;
      S_CLEAR: begin
        w_byte = CMD_CD;
        w_nx = w_done ? S_IDLE : S_CLEAR;
      end
      default: begin
        w_byte = r_ph ? w_fb : sddram(r_row, COLS);
        w_rs = r_ph;
        w_nx = w_done && r_ph && r_col == 5'(COLS - 1) && r_row == 2'(ROWS - 1) ? S_IDLE : S_REFRESH;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_st <= S_PWR;
      r_cnt <= 32'(T_PWR - 1);
      r_idx <= '0;
      r_row <= '0;
      r_col <= '0;
      r_ph <= 1'b0;
      r_init <= 1'b0;
      r_clr_p <= 1'b0;
      r_trg_p <= 1'b0;
    end else begin
      r_st <= w_nx;
      if (r_st == S_PWR && r_cnt != 0) r_cnt <= r_cnt - 32'd1;
      r_idx <= w_nx != r_st ? 2'd0 : r_idx + 2'(w_done);
      if (r_st == S_CFG && w_nx == S_IDLE) r_init <= 1'b1;
      r_clr_p <= (r_clr_p && r_st != S_IDLE) || i_clr;
      r_trg_p <= (r_trg_p && !(r_st == S_IDLE && !r_clr_p)) || i_trg;
      if (r_st == S_IDLE) begin
        r_row <= '0;
        r_col <= '0;
        r_ph <= 1'b0;
      end else if (r_st == S_REFRESH && w_done) begin
        r_ph <= !r_ph || r_col != 5'(COLS - 1);
        r_col <= !r_ph || r_col == 5'(COLS - 1) ? 5'd0 : r_col + 5'd1;
        if (r_ph && r_col == 5'(COLS - 1)) r_row <= r_row + 2'd1;
      end
    end
  always_ff @(posedge clk)
    if (w_wr_ok) r_fb[{i_wr_row, i_wr_col}] <= i_wr_data;
  hd44780_lcd_ctrl_xfer #(
    .BUS_WIDTH(BUS_WIDTH), .T_E(T_E), .T_CMD(T_CMD), .T_CLR(T_CLR)
  ) u_xfer (
    .clk(clk), .rst_n(rst_n), .i_start(w_start), .i_byte(w_byte), .i_rs(w_rs),
    .i_single(w_single), .i_long(w_long), .o_idle(w_idle), .o_done(w_done),
    .o_e(o_e), .o_rs(o_rs), .o_db(o_db)
  );
endmodule

// File: tb/tb_hd44780_lcd_ctrl.sv
// tb_hd44780_lcd_ctrl: 4-bit and 8-bit instances driven together, strobes checked against a byte-level model
module tb_hd44780_lcd_ctrl;
  localparam int ROWS = 2, COLS = 8, T_E = 2, T_CMD = 4, T_CLR = 8, T_PWR = 16;
  typedef struct {logic [7:0] v; logic rs; int gap;} stb_t;
  logic clk = 0, rst_n = 0, wr_en = 0, trg = 0, clr = 0;
  logic [1:0] wr_row = 0;
  logic [4:0] wr_col = 0;
  logic [7:0] wr_data = 0;
  logic [1:0] busy, idn, e, rs;
  logic [3:0] db4;
  logic [7:0] db8;
  logic [7:0] db_w [2];
  int n_chk = 0, n_fail = 0;
  stb_t got4[$], got8[$], exp4[$], exp8[$];
  int ng4, ng8;
  logic [7:0] mfb [ROWS][COLS];
  logic pe [2];
  logic [8:0] pdb [2];
  int hc [2], gc [2];
  always #5 clk = ~clk;
  assign db_w[0] = {4'h0, db4};
  assign db_w[1] = db8;
  hd44780_lcd_ctrl #(.BUS_WIDTH(4), .ROWS(ROWS), .COLS(COLS), .T_E(T_E), .T_CMD(T_CMD), .T_CLR(T_CLR), .T_PWR(T_PWR)) dut4 (
    .clk(clk), .rst_n(rst_n), .i_wr_en(wr_en), .i_wr_row(wr_row), .i_wr_col(wr_col), .i_wr_data(wr_data),
    .i_trg(trg), .i_clr(clr), .o_busy(busy[0]), .o_init_done(idn[0]), .o_e(e[0]), .o_rs(rs[0]), .o_db(db4));
  hd44780_lcd_ctrl #(.BUS_WIDTH(8), .ROWS(ROWS), .COLS(COLS), .T_E(T_E), .T_CMD(T_CMD), .T_CLR(T_CLR), .T_PWR(T_PWR)) dut8 (
    .clk(clk), .rst_n(rst_n), .i_wr_en(wr_en), .i_wr_row(wr_row), .i_wr_col(wr_col), .i_wr_data(wr_data),
    .i_trg(trg), .i_clr(clr), .o_busy(busy[1]), .o_init_done(idn[1]), .o_e(e[1]), .o_rs(rs[1]), .o_db(db8));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // Strobe capture: value at E rise, E width, bus stability and low time before each rise
  always @(negedge clk)
    for (int k = 0; k < 2; k++)
      if (!rst_n) begin
        pe[k] <= 1'b0;
        hc[k] <= 0;
        gc[k] <= 0;
      end else begin
        pe[k] <= e[k];
        pdb[k] <= {rs[k], db_w[k]};
        if (e[k] && !pe[k]) begin
          chk($sformatf("setup%0d", k), {rs[k], db_w[k]}, pdb[k]);
          if (k == 0) got4.push_back('{v: db_w[k], rs: rs[k], gap: gc[k]});
          else got8.push_back('{v: db_w[k], rs: rs[k], gap: gc[k]});
          hc[k] <= 1;
        end else if (e[k]) begin
          chk($sformatf("hold%0d", k), {rs[k], db_w[k]}, pdb[k]);
          hc[k] <= hc[k] + 1;
        end else if (pe[k]) begin
          chk($sformatf("e_width%0d", k), hc[k], T_E);
          gc[k] <= 1;
        end else gc[k] <= gc[k] + 1;
      end
  task automatic add4(input logic [3:0] v, input logic r, input int w);
    exp4.push_back('{v: {4'h0, v}, rs: r, gap: ng4});
    ng4 = T_E + w;
  endtask
  task automatic add8(input logic [7:0] v, input logic r, input int w);
    exp8.push_back('{v: v, rs: r, gap: ng8});
    ng8 = T_E + w;
  endtask
  task automatic xb(input logic [7:0] b4, input logic [7:0] b8, input logic r);
    add4(b4[7:4], r, 0);
    add4(b4[3:0], r, (!r && b4 == 8'h01) ? T_CLR : T_CMD);
    add8(b8, r, (!r && b8 == 8'h01) ? T_CLR : T_CMD);
  endtask
  task automatic exp_init();
    repeat (3) begin
      add4(4'h3, 1'b0, T_CLR);
      add8(8'h30, 1'b0, T_CLR);
    end
    add4(4'h2, 1'b0, T_CMD);
    xb(8'h28, 8'h38, 1'b0);
    xb(8'h0C, 8'h0C, 1'b0);
    xb(8'h01, 8'h01, 1'b0);
    xb(8'h06, 8'h06, 1'b0);
  endtask
  task automatic exp_refresh();
    int base [4];
    base = '{0, 'h40, COLS, 'h40 + COLS};
    for (int r = 0; r < ROWS; r++) begin
      xb(8'('h80 + base[r]), 8'('h80 + base[r]), 1'b0);
      for (int c = 0; c < COLS; c++) xb(mfb[r][c], mfb[r][c], 1'b1);
    end
  endtask
  task automatic cmp(input string tag);
    chk({tag, "_cnt4"}, got4.size(), exp4.size());
    chk({tag, "_cnt8"}, got8.size(), exp8.size());
    for (int i = 0; i < got4.size() && i < exp4.size(); i++) begin
      chk($sformatf("%s_b4[%0d]", tag, i), {got4[i].rs, got4[i].v}, {exp4[i].rs, exp4[i].v});
      if (exp4[i].gap > 0) chk($sformatf("%s_gap4[%0d]", tag, i), 32'(got4[i].gap >= exp4[i].gap), 1);
    end
    for (int i = 0; i < got8.size() && i < exp8.size(); i++) begin
      chk($sformatf("%s_b8[%0d]", tag, i), {got8[i].rs, got8[i].v}, {exp8[i].rs, exp8[i].v});
      if (exp8[i].gap > 0) chk($sformatf("%s_gap8[%0d]", tag, i), 32'(got8[i].gap >= exp8[i].gap), 1);
    end
    got4.delete();
    got8.delete();
    exp4.delete();
    exp8.delete();
  endtask
  task automatic wait_idle(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy != 2'b00 && n < 3000);
    chk({tag, "_idle"}, busy, 2'b00);
  endtask
  task automatic wr(input int r, input int c, input logic [7:0] d);
    @(negedge clk);
    wr_en = 1;
    wr_row = 2'(r);
    wr_col = 5'(c);
    wr_data = d;
    @(negedge clk);
    wr_en = 0;
    if (r < ROWS && c < COLS) mfb[r][c] = d;
  endtask
  task automatic pulse(input logic t, input logic c);
    @(negedge clk);
    trg = t;
    clr = c;
    @(negedge clk);
    trg = 0;
    clr = 0;
  endtask
  initial begin
    int n;
    ng4 = T_PWR;
    ng8 = T_PWR;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 2'b11);
    chk("rst_init_done", idn, 2'b00);
    chk("rst_e", e, 2'b00);
    chk("rst_rs", rs, 2'b00);
    chk("rst_db", {db8, db4}, 0);
    rst_n = 1;
    for (int i = 0; i < 16; i++) wr(i / 8, i % 8, 8'($urandom));
    chk("init_busy", busy, 2'b11);
    chk("init_pending", idn, 2'b00);
    exp_init();
    wait_idle("init");
    chk("init_done", idn, 2'b11);
    cmp("init");
    for (int c = 0; c < COLS; c++) begin
      wr(0, c, 8'h41 + 8'(c));
      wr(1, c, 8'h31 + 8'(c));
    end
    pulse(1, 0);
    exp_refresh();
    wait_idle("text");
    cmp("text");
    for (int it = 0; it < 4; it++) begin
      repeat (6) wr($urandom_range(3), $urandom_range(15), 8'($urandom));
      wr(2, it, 8'h55);
      wr(it % 2, 9, 8'h66);
      if (it == 3) begin
        pulse(1, 1);
        xb(8'h01, 8'h01, 1'b0);
      end else pulse(1, 0);
      exp_refresh();
      wait_idle($sformatf("rnd%0d", it));
      cmp($sformatf("rnd%0d", it));
    end
    pulse(1, 0);
    repeat (8) @(negedge clk);
    wr(1, 3, 8'h5A);
    exp_refresh();
    wait_idle("late_wr");
    cmp("late_wr");
    pulse(1, 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!e[0] && n < 500);
    chk("e_high_before_rst", e[0], 1'b1);
    #2 rst_n = 0;
    #1;
    chk("arst_e", e, 2'b00);
    chk("arst_db", {db8, db4}, 0);
    chk("arst_rs", rs, 2'b00);
    chk("arst_busy", busy, 2'b11);
    chk("arst_init_done", idn, 2'b00);
    repeat (3) @(negedge clk);
    got4.delete();
    got8.delete();
    exp4.delete();
    exp8.delete();
    ng4 = T_PWR;
    ng8 = T_PWR;
    rst_n = 1;
    repeat (20) @(negedge clk);
    pulse(1, 0);
    repeat (5) @(negedge clk);
    pulse(0, 1);
    repeat (5) @(negedge clk);
    pulse(1, 0);
    chk("replay_busy", busy, 2'b11);
    chk("replay_pending", idn, 2'b00);
    exp_init();
    xb(8'h01, 8'h01, 1'b0);
    exp_refresh();
    wait_idle("replay");
    chk("replay_init_done", idn, 2'b11);
    cmp("replay");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
